// File: rtl/tx_bit_framer_if.sv
// tx_bit_framer_if
// Handshake and modulator-side signals of the transmit bit framer.
// master: controlling logic (drives start/len and the payload byte stream).
// slave : the framer itself.
interface tx_bit_framer_if;
  logic       start;
  logic [7:0] len;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       data;
  logic       mod_ena;
  logic       busy;
  logic       done;
  logic       underrun;

  modport master (
    output start, len, byte_in, byte_valid,
    input  byte_ready, data, mod_ena, busy, done, underrun
  );

  modport slave (
    input  start, len, byte_in, byte_valid,
    output byte_ready, data, mod_ena, busy, done, underrun
  );
endinterface

// File: rtl/tx_bit_framer.sv
// tx_bit_framer
// Serializes preamble, sync word, length byte and payload (MSB first) for the
// BPSK mixer. Every bit is held for SAMPLES_PER_BIT clocks so it spans whole
// sine periods. Payload bytes arrive through a one-byte holding register; an
// empty holding register at a byte boundary aborts the frame (underrun).
// Optional feature macro: TX_FRAMER_CRC_EN appends a CRC-8 (poly 0x07,
// init 0x00) computed over the length byte and the payload.
module tx_bit_framer #(
  parameter int          SAMPLES_PER_BIT = 16,
  parameter int          PREAMBLE_BITS   = 32,
  parameter logic [15:0] SYNC_WORD       = 16'hD391
) (
  input  logic            clk,
  input  logic            rst_n,
  tx_bit_framer_if.slave  bus
);

  localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
  localparam int BIT_W = $clog2((PREAMBLE_BITS > 16) ? PREAMBLE_BITS : 16);

  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SAMPLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMP_ZERO = CNT_W'(0);
  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
  localparam logic [BIT_W-1:0] SYNC_LAST = BIT_W'(15);
  localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);
  localparam logic [BIT_W-1:0] BIT_ZERO  = BIT_W'(0);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SYNC     = 3'd2;
  localparam logic [2:0] ST_LEN      = 3'd3;
  localparam logic [2:0] ST_PAYLOAD  = 3'd4;
`ifdef TX_FRAMER_CRC_EN
  localparam logic [2:0] ST_CRC      = 3'd5;

  // CRC-8, poly 0x07, MSB first, folding one whole byte into the running value
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] byte_val);
    logic [7:0] c;
    c = crc_in ^ byte_val;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ 8'h07;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction
`endif

  // Registered state
  logic [2:0]       state_r;
  logic [CNT_W-1:0] samp_r;
  logic [BIT_W-1:0] bit_r;
  logic [14:0]      shift_r;     // bits still to send in the current field
  logic [7:0]       hold_r;
  logic             hold_full_r;
  logic [7:0]       fetch_r;     // payload bytes still to accept
  logic [7:0]       send_r;      // payload bytes still to load into the shifter
  logic [7:0]       len_r;
  logic             data_r;
  logic             mod_ena_r;
  logic             busy_r;
  logic             done_r;
  logic             underrun_r;
  logic             byte_ready_r;
`ifdef TX_FRAMER_CRC_EN
  logic [7:0]       crc_r;
  logic [7:0]       crc_s;
`endif

  // Next-state values
  logic [2:0]       state_s;
  logic [CNT_W-1:0] samp_s;
  logic [BIT_W-1:0] bit_s;
  logic [14:0]      shift_s;
  logic [7:0]       hold_s;
  logic             hold_full_s;
  logic [7:0]       fetch_s;
  logic [7:0]       send_s;
  logic [7:0]       len_s;
  logic             data_s;
  logic             mod_ena_s;
  logic             busy_s;
  logic             done_s;
  logic             underrun_s;
  logic             byte_ready_s;
  logic             finish_s;
  logic             abort_s;

  logic             wrap_s;
  logic             xfer_s;

  assign wrap_s = (samp_r == SAMP_LAST);
  // byte_ready_r is only ever high in LEN/PAYLOAD, so byte_valid elsewhere is ignored
  assign xfer_s = bus.byte_valid && byte_ready_r;

  assign bus.data       = data_r;
  assign bus.mod_ena    = mod_ena_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.underrun   = underrun_r;
  assign bus.byte_ready = byte_ready_r;

  // Frame sequencing, bit timing, byte intake and output next-state logic
  always_comb begin
    state_s     = state_r;
    samp_s      = samp_r;
    bit_s       = bit_r;
    shift_s     = shift_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    fetch_s     = fetch_r;
    send_s      = send_r;
    len_s       = len_r;
    data_s      = data_r;
    mod_ena_s   = mod_ena_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    underrun_s  = 1'b0;
    finish_s    = 1'b0;
    abort_s     = 1'b0;
`ifdef TX_FRAMER_CRC_EN
    crc_s       = crc_r;
`endif

    // Sample counter free-runs across the whole frame
    if (state_r == ST_IDLE) begin
      samp_s = SAMP_ZERO;
    end else if (wrap_s) begin
      samp_s = SAMP_ZERO;
    end else begin
      samp_s = samp_r + CNT_W'(1);
    end

    // Accept a payload byte into the holding register
    if (xfer_s) begin
      hold_s      = bus.byte_in;
      hold_full_s = 1'b1;
      fetch_s     = fetch_r - 8'd1;
    end else begin
      hold_s      = hold_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s     = ST_PREAMBLE;
          bit_s       = BIT_ZERO;
          shift_s     = 15'h0000;
          data_s      = 1'b1;
          mod_ena_s   = 1'b1;
          busy_s      = 1'b1;
          len_s       = bus.len;
          fetch_s     = bus.len;
          send_s      = bus.len;
          hold_full_s = 1'b0;
`ifdef TX_FRAMER_CRC_EN
          crc_s       = 8'h00;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_PREAMBLE: begin
        if (!wrap_s) begin
          state_s = ST_PREAMBLE;
        end else if (bit_r == PRE_LAST) begin
          state_s = ST_SYNC;
          bit_s   = BIT_ZERO;
          data_s  = SYNC_WORD[15];
          shift_s = SYNC_WORD[14:0];
        end else begin
          bit_s  = bit_r + BIT_W'(1);
          data_s = ~data_r;
        end
      end

      ST_SYNC: begin
        if (!wrap_s) begin
          state_s = ST_SYNC;
        end else if (bit_r == SYNC_LAST) begin
          state_s = ST_LEN;
          bit_s   = BIT_ZERO;
          data_s  = len_r[7];
          shift_s = {len_r[6:0], 8'h00};
`ifdef TX_FRAMER_CRC_EN
          crc_s   = crc8_byte(crc_r, len_r);
`endif
        end else begin
          bit_s   = bit_r + BIT_W'(1);
          data_s  = shift_r[14];
          shift_s = {shift_r[13:0], 1'b0};
        end
      end

      ST_LEN, ST_PAYLOAD: begin
        if (!wrap_s) begin
          state_s = state_r;
        end else if (bit_r != BYTE_LAST) begin
          bit_s   = bit_r + BIT_W'(1);
          data_s  = shift_r[14];
          shift_s = {shift_r[13:0], 1'b0};
        end else if (send_r != 8'd0) begin
          // Byte boundary with payload pending: the holding register must be full
          if (hold_full_r) begin
            state_s     = ST_PAYLOAD;
            bit_s       = BIT_ZERO;
            data_s      = hold_r[7];
            shift_s     = {hold_r[6:0], 8'h00};
            hold_full_s = 1'b0;
            send_s      = send_r - 8'd1;
`ifdef TX_FRAMER_CRC_EN
            crc_s       = crc8_byte(crc_r, hold_r);
`endif
          end else begin
            abort_s = 1'b1;
          end
        end else begin
`ifdef TX_FRAMER_CRC_EN
          state_s = ST_CRC;
          bit_s   = BIT_ZERO;
          data_s  = crc_r[7];
          shift_s = {crc_r[6:0], 8'h00};
`else
          finish_s = 1'b1;
`endif
        end
      end

`ifdef TX_FRAMER_CRC_EN
      ST_CRC: begin
        if (!wrap_s) begin
          state_s = ST_CRC;
        end else if (bit_r == BYTE_LAST) begin
          finish_s = 1'b1;
        end else begin
          bit_s   = bit_r + BIT_W'(1);
          data_s  = shift_r[14];
          shift_s = {shift_r[13:0], 1'b0};
        end
      end
`endif

      default: begin
        // Unreachable encoding: fall back to a quiet IDLE
        abort_s = 1'b1;
      end
    endcase

    // Frame end (normal or aborted) returns everything to the idle picture
    if (finish_s || abort_s) begin
      state_s     = ST_IDLE;
      bit_s       = BIT_ZERO;
      shift_s     = 15'h0000;
      data_s      = 1'b0;
      mod_ena_s   = 1'b0;
      busy_s      = 1'b0;
      hold_full_s = 1'b0;
      fetch_s     = 8'd0;
      send_s      = 8'd0;
      done_s      = finish_s;
      underrun_s  = abort_s && (state_r != ST_IDLE) && (state_r != ST_PREAMBLE)
                    && (state_r != ST_SYNC);
    end else begin
      done_s      = 1'b0;
    end

    byte_ready_s = !hold_full_s && (fetch_s != 8'd0) &&
                   ((state_s == ST_LEN) || (state_s == ST_PAYLOAD));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      samp_r       <= SAMP_ZERO;
      bit_r        <= BIT_ZERO;
      shift_r      <= 15'h0000;
      hold_r       <= 8'h00;
      hold_full_r  <= 1'b0;
      fetch_r      <= 8'd0;
      send_r       <= 8'd0;
      len_r        <= 8'd0;
      data_r       <= 1'b0;
      mod_ena_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      underrun_r   <= 1'b0;
      byte_ready_r <= 1'b0;
`ifdef TX_FRAMER_CRC_EN
      crc_r        <= 8'h00;
`endif
    end else begin
      state_r      <= state_s;
      samp_r       <= samp_s;
      bit_r        <= bit_s;
      shift_r      <= shift_s;
      hold_r       <= hold_s;
      hold_full_r  <= hold_full_s;
      fetch_r      <= fetch_s;
      send_r       <= send_s;
      len_r        <= len_s;
      data_r       <= data_s;
      mod_ena_r    <= mod_ena_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      underrun_r   <= underrun_s;
      byte_ready_r <= byte_ready_s;
`ifdef TX_FRAMER_CRC_EN
      crc_r        <= crc_s;
`endif
    end
  end

endmodule

// File: tb/tb_tx_bit_framer.sv
// tb_tx_bit_framer
// Directed bench for tx_bit_framer with SAMPLES_PER_BIT=4, PREAMBLE_BITS=8.
// Honours TX_FRAMER_CRC_EN: frame lengths grow by one byte and the CRC
// vector is exercised when the macro is defined.
module tb_tx_bit_framer;

  localparam int SPB = 4;
  localparam int PRE = 8;
`ifdef TX_FRAMER_CRC_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif

  logic clk;
  logic rst_n;

  tx_bit_framer_if bus_if ();

  tx_bit_framer #(
    .SAMPLES_PER_BIT (SPB),
    .PREAMBLE_BITS   (PRE),
    .SYNC_WORD       (16'hD391)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent run_frame call
  logic [127:0] res_bits;
  int           res_nbits;
  int           res_cycles;
  int           res_done_k;
  int           res_under_k;
  int           res_glitch;
  int           res_busy_bad;
  logic         res_ready_seen;
  logic         res_timeout;
  logic [2:0]   res_first;
  logic [2:0]   res_end;
  logic [7:0]   pay [0:3];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues start at the current negedge, feeds nfeed bytes from pay[], and
  // watches the frame cycle by cycle (k = cycles after the accepting edge).
  task automatic run_frame(input logic [7:0] l, input int nfeed, input int mid_start_k);
    int   fed;
    logic prev_ready;
    logic last_data;
    res_bits       = '0;
    res_nbits      = 0;
    res_cycles     = 0;
    res_done_k     = 0;
    res_under_k    = 0;
    res_glitch     = 0;
    res_busy_bad   = 0;
    res_ready_seen = 1'b0;
    res_timeout    = 1'b1;
    res_first      = 3'b000;
    res_end        = 3'b111;
    fed            = 0;
    last_data      = 1'b0;
    bus_if.start      = 1'b1;
    bus_if.len        = l;
    bus_if.byte_valid = (nfeed > 0);
    bus_if.byte_in    = pay[0];
    prev_ready        = bus_if.byte_ready;
    for (int k = 1; k <= 1500; k++) begin
      @(negedge clk);
      if (k == 1) res_first = {bus_if.busy, bus_if.mod_ena, bus_if.data};
      if (bus_if.mod_ena) begin
        res_cycles++;
        if (!bus_if.busy) res_busy_bad++;
        if (((k - 1) % SPB) == 0) begin
          res_bits  = {res_bits[126:0], bus_if.data};
          res_nbits++;
        end else if (bus_if.data !== last_data) begin
          res_glitch++;
        end
      end
      last_data = bus_if.data;
      if (bus_if.byte_ready) res_ready_seen = 1'b1;
      if (prev_ready && bus_if.byte_valid) fed++;
      prev_ready        = bus_if.byte_ready;
      bus_if.byte_valid = (fed < nfeed);
      bus_if.byte_in    = pay[(fed < 4) ? fed : 0];
      bus_if.start      = (k == mid_start_k);
      if (bus_if.done) res_done_k = k;
      if (bus_if.underrun) res_under_k = k;
      if (bus_if.done || bus_if.underrun) begin
        res_end     = {bus_if.busy, bus_if.mod_ena, bus_if.data};
        res_timeout = 1'b0;
        break;
      end
    end
    bus_if.start      = 1'b0;
    bus_if.byte_valid = 1'b0;
  endtask

  initial begin
    logic [47:0] exp48;
    logic [39:0] exp40;
    logic [31:0] exp32;
    logic [127:0] shifted;
    int n;

    rst_n             = 1'b0;
    bus_if.start      = 1'b0;
    bus_if.len        = 8'd0;
    bus_if.byte_in    = 8'h00;
    bus_if.byte_valid = 1'b0;
    for (int i = 0; i < 4; i++) pay[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_val("reset_outputs",
              {bus_if.busy, bus_if.mod_ena, bus_if.data, bus_if.done, bus_if.underrun, bus_if.byte_ready},
              6'b000000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_outputs",
              {bus_if.busy, bus_if.mod_ena, bus_if.data, bus_if.done, bus_if.underrun, bus_if.byte_ready},
              6'b000000);

    // Frame 1: len=2, A5 3C always available
    pay[0] = 8'hA5; pay[1] = 8'h3C;
    run_frame(8'd2, 2, 0);
    n = (PRE + 24 + 16 + CRC_BITS) * SPB;
    exp48 = 48'hAA_D391_02_A5_3C;
    shifted = res_bits >> CRC_BITS;
    check_val("f1_timeout", res_timeout, 1'b0);
    check_val("f1_first_bit", res_first, 3'b111);
    check_val("f1_mod_ena_cycles", res_cycles, n);
    check_val("f1_done_cycle", res_done_k, n + 1);
    check_val("f1_no_underrun", res_under_k, 0);
    check_val("f1_nbits", res_nbits, PRE + 24 + 16 + CRC_BITS);
    check_val("f1_bits", shifted[47:0], exp48);
    check_val("f1_end_outputs", res_end, 3'b000);
    check_val("f1_data_stable", res_glitch, 0);
    check_val("f1_busy_with_mod", res_busy_bad, 0);
    check_val("f1_ready_seen", res_ready_seen, 1'b1);

    // Frame 2 back-to-back (start on the done cycle): len=0
    run_frame(8'd0, 0, 0);
    n = (PRE + 24 + CRC_BITS) * SPB;
    exp32 = 32'hAA_D391_00;
    shifted = res_bits >> CRC_BITS;
    check_val("f2_timeout", res_timeout, 1'b0);
    check_val("f2_first_bit", res_first, 3'b111);
    check_val("f2_mod_ena_cycles", res_cycles, n);
    check_val("f2_done_cycle", res_done_k, n + 1);
    check_val("f2_bits", shifted[31:0], exp32);
    check_val("f2_ready_never", res_ready_seen, 1'b0);

    // Frame 3: start pulsed mid-frame is ignored
    repeat (3) @(negedge clk);
    pay[0] = 8'h5A;
    run_frame(8'd1, 1, 50);
    n = (PRE + 24 + 8 + CRC_BITS) * SPB;
    exp40 = 40'hAA_D391_01_5A;
    shifted = res_bits >> CRC_BITS;
    check_val("f3_mod_ena_cycles", res_cycles, n);
    check_val("f3_done_cycle", res_done_k, n + 1);
    check_val("f3_bits", shifted[39:0], exp40);
    repeat (4) @(negedge clk);
    check_val("f3_no_restart", {bus_if.busy, bus_if.mod_ena}, 2'b00);

    // Frame 4: len=2 but only one byte supplied -> underrun after byte 1
    pay[0] = 8'hC3; pay[1] = 8'h77;
    run_frame(8'd2, 1, 0);
    n = (PRE + 24 + 8) * SPB;
    exp40 = 40'hAA_D391_02_C3;
    check_val("f4_underrun_cycle", res_under_k, n + 1);
    check_val("f4_no_done", res_done_k, 0);
    check_val("f4_mod_ena_cycles", res_cycles, n);
    check_val("f4_bits", res_bits[39:0], exp40);
    check_val("f4_end_outputs", res_end, 3'b000);
    @(negedge clk);
    check_val("f4_after_abort",
              {bus_if.busy, bus_if.mod_ena, bus_if.underrun, bus_if.byte_ready}, 4'b0000);

`ifdef TX_FRAMER_CRC_EN
    // CRC frame: len=1, payload 0x00 -> CRC-8 over {01,00} = 0x15
    pay[0] = 8'h00;
    run_frame(8'd1, 1, 0);
    check_val("crc_nbits", res_nbits, 48);
    check_val("crc_mod_ena_cycles", res_cycles, 48 * SPB);
    check_val("crc_byte", res_bits[7:0], 8'h15);
    check_val("crc_done_cycle", res_done_k, 48 * SPB + 1);
`endif

    // Asynchronous reset during SYNC, then a clean frame
    @(negedge clk);
    bus_if.len   = 8'd1;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (40) @(negedge clk);
    check_val("rst_mid_active", bus_if.mod_ena, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("rst_async_clear",
              {bus_if.busy, bus_if.mod_ena, bus_if.data, bus_if.done, bus_if.underrun, bus_if.byte_ready},
              6'b000000);
    @(negedge clk);
    check_val("rst_no_done", {bus_if.done, bus_if.underrun}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    pay[0] = 8'h96;
    run_frame(8'd1, 1, 0);
    n = (PRE + 24 + 8 + CRC_BITS) * SPB;
    exp40 = 40'hAA_D391_01_96;
    shifted = res_bits >> CRC_BITS;
    check_val("rst_frame_cycles", res_cycles, n);
    check_val("rst_frame_done", res_done_k, n + 1);
    check_val("rst_frame_bits", shifted[39:0], exp40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_bit_framer.md
# tx_bit_framer

Transmit-side bit framer that feeds the BPSK mixer stage. Accepts payload bytes over a valid/ready handshake and serializes a frame MSB-first: preamble, sync word, length byte, then payload. Each bit is held for a fixed number of clocks so that it spans whole sine periods. Drives the mixer's `data` and `mod_ena` inputs directly and reports frame completion or underrun to the controlling logic.

## Interface
Parameters:
- `SAMPLES_PER_BIT`, 16, clocks per bit (≥2); equals the sine LUT period.
- `PREAMBLE_BITS`, 32, preamble length in bits (≥1, even).
- `SYNC_WORD`, 16'hD391, 16-bit sync pattern sent after the preamble.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to send a frame; honoured only in IDLE.
- `len`  in  8  payload byte count, latched on an accepted `start`; 0 is legal.
- `byte_in`  in  8  payload byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  framer can accept a byte this cycle.
- `data`  out  1  current bit, to the mixer `data` input.
- `mod_ena`  out  1  frame bit active, to the mixer `mod_ena` input.
- `busy`  out  1  high from the accepted `start` until the frame ends or aborts.
- `done`  out  1  one-cycle pulse on normal frame completion.
- `underrun`  out  1  one-cycle pulse when a payload byte is missing at its boundary.

## Operation
- States: IDLE → PREAMBLE → SYNC → LEN → PAYLOAD → (CRC) → IDLE.
- Bit timing: a sample counter counts 0..SAMPLES_PER_BIT-1. Each bit is held for the full count. The bit index advances when the counter wraps.
- PREAMBLE: alternating bits starting with 1, for PREAMBLE_BITS bits.
- SYNC: SYNC_WORD, MSB first.
- LEN: latched `len`, MSB first. If `len`==0, the next state is CRC when configured, otherwise IDLE.
- PAYLOAD: bytes are sent MSB first. The framer keeps a 1-byte holding register and a remaining-byte counter.
  - `byte_ready` = holding register empty AND bytes still to fetch > 0 AND state ∈ {LEN, PAYLOAD}.
  - Transfer occurs when `byte_valid` && `byte_ready`.
  - At each byte boundary (counter wrap on bit 7 of LEN or of a payload byte, more payload pending), the holding register moves into the shift register.
  - If the holding register is empty at that boundary, the frame aborts: pulse `underrun`, drop `mod_ena`, clear `busy`, return to IDLE, discard state.
- `start` is ignored while `busy`. `byte_valid` is ignored outside {LEN, PAYLOAD}.
- Reset values: `data`=0, `mod_ena`=0, `busy`=0, `done`=0, `underrun`=0, `byte_ready`=0; holding register empty; state IDLE.
- Asserting `rst_n` low mid-frame clears all outputs immediately, with no completion pulse.

## Timing
- Accepted `start` at cycle T: `busy`, `mod_ena`, and the first preamble bit (1) are registered and visible from T+1.
- All outputs are registered. `data` changes only at bit boundaries.
- Frame duration N = (PREAMBLE_BITS + 24 + 8·len [+8 with CRC]) · SAMPLES_PER_BIT clocks. `mod_ena` is high for exactly N cycles, from T+1 through T+N.
- At T+N+1: `mod_ena`=0, `busy`=0, `done`=1 for one cycle, `data`=0.
- `start` at T+N+1 is accepted, giving back-to-back frames with a 1-cycle gap.
- Abort on underrun: `underrun` pulses in the cycle after the failed boundary. `mod_ena` and `busy` fall in that same cycle.

## Configuration
- `TX_FRAMER_CRC_EN` defined:
  - Adds a CRC state after the payload (or after LEN when `len`==0).
  - Sends CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over the length byte and the payload, MSB first.
  - CRC is updated as each byte is loaded into the shift register.
- Undefined: no CRC state, no CRC logic, frame ends after the last payload bit.

## Test plan
- SAMPLES_PER_BIT=4, PREAMBLE_BITS=8, start with len=2, bytes 0xA5,0x3C always valid → `mod_ena` high 192 cycles; bit stream 10101010, D391, 02, A5, 3C; `done` pulse at T+193.
- len=0, no CRC → 32 bits (128 clocks), `byte_ready` never asserts, `done` at T+129.
- `TX_FRAMER_CRC_EN`, len=1, byte 0x00 → trailing CRC byte 0x15, 48 bits total.
- len=2, first byte supplied, `byte_valid` held low afterwards → `underrun` pulse at the end of byte 1's last bit, `mod_ena`/`busy` fall, no `done`.
- `start` pulsed mid-frame → ignored; frame length unchanged.
- `rst_n` low during SYNC → all outputs 0 asynchronously; after release, a fresh `start` produces a correct full frame.
